// File: rtl/gpio_in_monitor.sv
// GPIO header input monitor: per-pin synchroniser and debounce, sticky edge flags,
// snapshot register, change counter, and one HEX digit per GPIO byte.
module gpio_in_monitor #(
  parameter int WIDTH           = 32,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter bit INVERT          = 1'b0
) (
  input  logic                   CLOCK_50,
  input  logic                   RESET,
  inout  wire  [WIDTH-1:0]       GPIO,
  input  logic [1:0]             MODE,
  input  logic                   CLEAR,
  input  logic                   CAPTURE,
  output logic [7*(WIDTH/8)-1:0] HEX,
  output logic                   EVENT,
  output logic [15:0]            EVENT_COUNT
);

  localparam int         DIGITS  = WIDTH / 8;
  localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CYCLES - 1);

  // The header is input-only.
  assign GPIO = {WIDTH{1'bz}};

  logic [WIDTH-1:0]          sync1_q, sync1_d, sync2_q, sync2_d;
  logic [WIDTH-1:0]          deb_q, deb_d;
  logic [WIDTH-1:0][7:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]          sticky_r_q, sticky_r_d, sticky_f_q, sticky_f_d;
  logic [WIDTH-1:0]          rise, fall;
  logic                      event_q, event_d;
  logic [15:0]               evcnt_q, evcnt_d;
  logic                      deb_changed;
  // Bit 7 of each byte is never displayed, so the snapshot keeps only the shown bits.
  logic [7*DIGITS-1:0]       snap_q, snap_d;
  logic [7*DIGITS-1:0]       hex_q, hex_d;

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      cnt_q      <= '0;
      sticky_r_q <= '0;
      sticky_f_q <= '0;
      event_q    <= 1'b0;
      evcnt_q    <= '0;
      snap_q     <= '0;
      hex_q      <= {(7*DIGITS){INVERT}};
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      cnt_q      <= cnt_d;
      sticky_r_q <= sticky_r_d;
      sticky_f_q <= sticky_f_d;
      event_q    <= event_d;
      evcnt_q    <= evcnt_d;
      snap_q     <= snap_d;
      hex_q      <= hex_d;
    end
  end

  always_comb begin
    sync1_d = GPIO;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        deb_d[i] = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end

    rise = deb_d & ~deb_q;
    fall = ~deb_d & deb_q;
    // A set on the same edge as CLEAR survives, so no event is lost.
    sticky_r_d = (CLEAR ? '0 : sticky_r_q) | rise;
    sticky_f_d = (CLEAR ? '0 : sticky_f_q) | fall;
    event_d    = |(sticky_r_d | sticky_f_d);

    deb_changed = |(deb_d ^ deb_q);
    if (CLEAR)
      evcnt_d = {15'd0, deb_changed};
    else if (deb_changed && (evcnt_q != 16'hFFFF))
      evcnt_d = evcnt_q + 16'd1;
    else
      evcnt_d = evcnt_q;

    snap_d = snap_q;
    if (CAPTURE) begin
      for (int d = 0; d < DIGITS; d++)
        snap_d[7*d +: 7] = deb_q[8*d +: 7];
    end
  end

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    logic [6:0] view;
    always_comb begin
      case (MODE)
        2'b00:   view = deb_q[8*gi +: 7];
        2'b01:   view = sticky_r_q[8*gi +: 7];
        2'b10:   view = sticky_f_q[8*gi +: 7];
        default: view = snap_q[7*gi +: 7];
      endcase
    end
    assign hex_d[7*gi +: 7] = view ^ {7{INVERT}};
  end

  assign HEX         = hex_q;
  assign EVENT       = event_q;
  assign EVENT_COUNT = evcnt_q;

endmodule

// File: tb/tb_gpio_in_monitor.sv
// Directed bench for gpio_in_monitor: two instances (INVERT=0 and INVERT=1) share all inputs.
module tb_gpio_in_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] gpio_drv;
  wire  [31:0] gpio;
  logic [1:0]  mode;
  logic        clear, capture;
  logic [27:0] hex, hex_inv;
  logic        event_o, event_inv;
  logic [15:0] evcnt, evcnt_inv;

  int checks   = 0;
  int failures = 0;

  assign gpio = gpio_drv;
  always #10 clk = ~clk;

  gpio_in_monitor #(.WIDTH(32), .DEBOUNCE_CYCLES(4), .INVERT(1'b0)) dut (
    .CLOCK_50(clk), .RESET(reset), .GPIO(gpio), .MODE(mode), .CLEAR(clear),
    .CAPTURE(capture), .HEX(hex), .EVENT(event_o), .EVENT_COUNT(evcnt)
  );

  gpio_in_monitor #(.WIDTH(32), .DEBOUNCE_CYCLES(4), .INVERT(1'b1)) dut_inv (
    .CLOCK_50(clk), .RESET(reset), .GPIO(gpio), .MODE(mode), .CLEAR(clear),
    .CAPTURE(capture), .HEX(hex_inv), .EVENT(event_inv), .EVENT_COUNT(evcnt_inv)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end else begin
      $display("ok   %s: %h", tag, act);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  logic [27:0] exp_snap, exp_snap_inv;

  initial begin
    reset = 1'b0; gpio_drv = 32'h0; mode = 2'b00; clear = 1'b0; capture = 1'b0;
    tick(2);

    // 1: reset state
    do_reset();
    check("rst_hex", hex, 28'h0);
    check("rst_hex_inv", hex_inv, 28'hFFFFFFF);
    check("rst_event", event_o, 1'b0);
    check("rst_count", evcnt, 16'h0);
    gpio_drv = 32'hA5C3_0F96;
    tick();
    check("gpio_not_driven", gpio, 32'hA5C3_0F96);
    gpio_drv = 32'h0;
    tick(8);

    // 2: step to a pattern, HEX appears at edge 6 and not before
    do_reset();
    gpio_drv = 32'h4F5B063F;
    tick(6);
    check("step_hex_edge5", hex, 28'h0);
    check("step_count", evcnt, 16'd1);
    check("step_event", event_o, 1'b1);
    tick();
    check("step_hex_edge6", hex, {7'h4F, 7'h5B, 7'h06, 7'h3F});

    // reset mid-debounce restarts the count from scratch
    gpio_drv = 32'h0;
    tick(8);
    do_reset();
    gpio_drv = 32'h1;
    tick(4);
    do_reset();
    tick(5);
    check("rst_mid_deb_none", evcnt, 16'd0);
    tick();
    check("rst_mid_deb_one", evcnt, 16'd1);

    // 3: 3-cycle glitch ignored, 4-cycle pulse accepted
    gpio_drv = 32'h0;
    do_reset();
    tick(2);
    gpio_drv = 32'h1;
    tick(3);
    gpio_drv = 32'h0;
    tick(10);
    check("glitch_count", evcnt, 16'd0);
    check("glitch_event", event_o, 1'b0);
    gpio_drv = 32'h1;
    tick(4);
    gpio_drv = 32'h0;
    tick(10);
    check("pulse_count", evcnt, 16'd2);
    check("pulse_event", event_o, 1'b1);
    mode = 2'b01;
    tick();
    check("pulse_sticky_r", hex, 28'h1);
    mode = 2'b10;
    tick();
    check("pulse_sticky_f", hex, 28'h1);
    mode = 2'b01;
    tick();

    // 4: CLEAR wipes flags and counter; HEX follows one edge later
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_event", event_o, 1'b0);
    check("clear_count", evcnt, 16'd0);
    check("clear_hex_lag", hex, 28'h1);
    tick();
    check("clear_hex", hex, 28'h0);

    // 5: CLEAR on the same edge that deb[3] rises
    gpio_drv = 32'h8;
    tick(5);
    check("clr_rise_pre_event", event_o, 1'b0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_rise_event", event_o, 1'b1);
    check("clr_rise_count", evcnt, 16'd1);
    tick();
    check("clr_rise_sticky", hex, 28'h08);

    // 6: snapshot holds across GPIO change and CLEAR
    exp_snap     = {7'h12, 7'h34, 7'h56, 7'h78};
    exp_snap_inv = ~exp_snap;
    gpio_drv = 32'h12345678;
    tick(8);
    capture = 1'b1;
    tick();
    capture = 1'b0;
    mode = 2'b11;
    tick();
    check("snap_hex", hex, exp_snap);
    check("snap_hex_inv", hex_inv, exp_snap_inv);
    gpio_drv = 32'hFFFFFFFF;
    tick(8);
    check("snap_hold", hex, exp_snap);
    check("snap_hold_inv", hex_inv, exp_snap_inv);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    check("snap_after_clear", hex, exp_snap);
    mode = 2'b00;
    tick();
    check("live_all_ones", hex, {4{7'h7F}});
    check("live_all_ones_inv", hex_inv, 28'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
